// File: rtl/key_event_pkg.sv
// Shared definitions for the key event queue.
//   EVT_SHORT / EVT_LONG : event type bit stored in the MSB of an event code.
//   event_width()        : width of an event code, {type, key_idx}.
package key_event_pkg;

    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

    // Event code is one type bit followed by the key index.
    function automatic int unsigned event_width(input int unsigned nkeys);
        return 1 + $clog2(nkeys);
    endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Valid/ready event channel from the key event queue to its consumer.
//   ev_valid : head of queue holds an event
//   ev_code  : event at head, {long, key_idx}
//   ev_ready : consumer accepts the head this cycle
// master = event producer, slave = event consumer.
interface key_event_queue_if #(
    parameter int unsigned CodeW = 3
) ();

    logic             ev_valid;
    logic [CodeW-1:0] ev_code;
    logic             ev_ready;

    modport master (
        output ev_valid,
        output ev_code,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        output ev_ready
    );

endinterface

// File: rtl/event_fifo.sv
// Small synchronous FIFO holding queued key events.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored while full)
//   full       : no free entry
//   pop, dout  : read request (ignored while empty) and head entry
//   count      : number of stored entries
// Simultaneous push and pop are both performed and leave count unchanged.
module event_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FullCnt);
    assign do_push = push && !full;
    assign do_pop  = pop && (count_q != '0);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            // Power-of-two depth: pointers wrap without compare logic.
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced, idle-high button levels into short/long press events and
// queues them for the vending control FSM.
//   clk, reset : clock, synchronous active-high reset
//   keys_n     : debounced key levels, 0 = pressed
//   ev         : valid/ready event channel (master side)
//   overflow   : sticky, set when an event had to be dropped
// A release before HOLD_LIMIT cycles of hold gives SHORT; reaching the limit
// while held gives LONG immediately and suppresses the later release event.
// Each key has one pending slot; the lowest pending index is written to the
// FIFO each cycle the FIFO has room.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int unsigned NKEYS      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned HOLD_LIMIT = 20'hF4240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NKEYS-1:0]   keys_n,
    key_event_queue_if.master  ev,
    output logic               overflow
);

    localparam int unsigned IdxW  = $clog2(NKEYS);
    localparam int unsigned CodeW = event_width(NKEYS);
    localparam int unsigned CntW  = $clog2(HOLD_LIMIT);
    localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_LIMIT - 1);

    logic [NKEYS-1:0] prev_n_q, prev_n_d;
    logic [CntW-1:0]  cnt_q [NKEYS];
    logic [CntW-1:0]  cnt_d [NKEYS];
    logic [NKEYS-1:0] long_done_q, long_done_d;
    logic [NKEYS-1:0] pend_q, pend_d;
    logic [NKEYS-1:0] pend_type_q, pend_type_d;
    logic             overflow_q, overflow_d;

    logic [NKEYS-1:0] grant;
    logic [IdxW-1:0]  grant_idx;
    logic             found;
    logic             push;
    logic [CodeW-1:0] push_code;
    logic [NKEYS-1:0] ev_fire;
    logic [NKEYS-1:0] ev_type;
    logic             fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;

    // Fixed-priority arbiter: lowest pending index wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (pend_q[i] && !found) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IdxW'(i);
            end
        end
        push      = found && !fifo_full;
        push_code = {pend_type_q[grant_idx], grant_idx};
    end

    // Per-key edge detection, hold counting and pend slot update.
    always_comb begin
        prev_n_d    = keys_n;
        cnt_d       = cnt_q;
        long_done_d = long_done_q;
        pend_d      = pend_q;
        pend_type_d = pend_type_q;
        overflow_d  = overflow_q;
        ev_fire     = '0;
        ev_type     = '0;

        for (int i = 0; i < NKEYS; i++) begin
            if (push && grant[i]) begin
                pend_d[i] = 1'b0;
            end

            if (keys_n[i]) begin
                cnt_d[i] = '0;
                if (!prev_n_q[i]) begin
                    if (long_done_q[i]) begin
                        long_done_d[i] = 1'b0;
                    end else begin
                        ev_fire[i] = 1'b1;
                        ev_type[i] = EVT_SHORT;
                    end
                end
            end else if (!long_done_q[i]) begin
                if (cnt_q[i] == HoldMax) begin
                    // Counter stays frozen at HoldMax until release.
                    ev_fire[i]     = 1'b1;
                    ev_type[i]     = EVT_LONG;
                    long_done_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end

            // A slot being drained this cycle is free for the new event.
            if (ev_fire[i]) begin
                if (pend_q[i] && !(push && grant[i])) begin
                    overflow_d = 1'b1;
                end else begin
                    pend_d[i]      = 1'b1;
                    pend_type_d[i] = ev_type[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_n_q    <= '1;
            cnt_q       <= '{default: '0};
            long_done_q <= '0;
            pend_q      <= '0;
            pend_type_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            prev_n_q    <= prev_n_d;
            cnt_q       <= cnt_d;
            long_done_q <= long_done_d;
            pend_q      <= pend_d;
            pend_type_q <= pend_type_d;
            overflow_q  <= overflow_d;
        end
    end

    event_fifo #(
        .WIDTH (CodeW),
        .DEPTH (DEPTH)
    ) u_event_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_code),
        .full  (fifo_full),
        .pop   (ev.ev_ready),
        .dout  (ev.ev_code),
        .count (fifo_count)
    );

    assign ev.ev_valid = (fifo_count != '0);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with NKEYS=4, DEPTH=4, HOLD_LIMIT=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_key_event_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys_n;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event_queue_if #(.CodeW(3)) ev_if ();

    key_event_queue #(
        .NKEYS      (4),
        .DEPTH      (4),
        .HOLD_LIMIT (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .keys_n   (keys_n),
        .ev       (ev_if),
        .overflow (overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int nvalid;
        reset = 1'b1;
        keys_n = 4'b1111;
        ev_if.ev_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (ev_if.ev_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ev_valid=%b overflow=%b, expected 0/0",
                     ev_if.ev_valid, overflow);
        end
        nvalid = 0;
        repeat (4) begin
            if (ev_if.ev_valid === 1'b1) nvalid++;
            step();
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d valid cycles, expected 0", nvalid);
        end
    endtask

    task automatic test_short_press();
        keys_n[2] = 1'b0;
        repeat (5) step();
        keys_n[2] = 1'b1;
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_n: ev_valid=%b, expected 0", ev_if.ev_valid);
        end
        step();
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_n1: ev_valid=%b, expected 0", ev_if.ev_valid);
        end
        step();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'b010) begin
            errors++;
            $display("FAIL short_n2: ev_valid=%b ev_code=%b, expected 1/010",
                     ev_if.ev_valid, ev_if.ev_code);
        end
        step();
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_n3: ev_valid=%b, expected 0", ev_if.ev_valid);
        end
    endtask

    task automatic test_long_press();
        int nvalid;
        nvalid = 0;
        keys_n[1] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 16) begin
                checks++;
                if (ev_if.ev_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL long_p16: ev_valid=%b, expected 0", ev_if.ev_valid);
                end
            end
            if (k == 17) begin
                checks++;
                if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'b101) begin
                    errors++;
                    $display("FAIL long_p17: ev_valid=%b ev_code=%b, expected 1/101",
                             ev_if.ev_valid, ev_if.ev_code);
                end
            end
            if (ev_if.ev_valid === 1'b1) nvalid++;
            step();
        end
        keys_n[1] = 1'b1;
        repeat (6) begin
            if (ev_if.ev_valid === 1'b1) nvalid++;
            step();
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL long_count: %0d events, expected 1", nvalid);
        end
    endtask

    task automatic test_simultaneous();
        keys_n[0] = 1'b0;
        keys_n[3] = 1'b0;
        repeat (3) step();
        keys_n[0] = 1'b1;
        keys_n[3] = 1'b1;
        step();
        step();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'b000) begin
            errors++;
            $display("FAIL simul_first: ev_valid=%b ev_code=%b, expected 1/000",
                     ev_if.ev_valid, ev_if.ev_code);
        end
        step();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'b011) begin
            errors++;
            $display("FAIL simul_second: ev_valid=%b ev_code=%b, expected 1/011",
                     ev_if.ev_valid, ev_if.ev_code);
        end
        step();
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_after: ev_valid=%b, expected 0", ev_if.ev_valid);
        end
    endtask

    task automatic test_backpressure();
        int nvalid;
        int badcode;
        ev_if.ev_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            keys_n[0] = 1'b0;
            step();
            step();
            keys_n[0] = 1'b1;
            step();
            step();
            step();
            if (j == 4) begin
                checks++;
                if (overflow !== 1'b0 || ev_if.ev_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_fifth: overflow=%b ev_valid=%b, expected 0/1",
                             overflow, ev_if.ev_valid);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_overflow: overflow=%b, expected 1", overflow);
        end
        ev_if.ev_ready = 1'b1;
        nvalid = 0;
        badcode = 0;
        repeat (10) begin
            if (ev_if.ev_valid === 1'b1) begin
                nvalid++;
                if (ev_if.ev_code !== 3'b000) badcode++;
            end
            step();
        end
        checks++;
        if (nvalid != 5 || badcode != 0) begin
            errors++;
            $display("FAIL bp_drain: %0d events (%0d bad codes), expected 5 (0)",
                     nvalid, badcode);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_sticky: overflow=%b, expected 1", overflow);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid;
        ev_if.ev_ready = 1'b0;
        keys_n[2] = 1'b0;
        step();
        step();
        keys_n[2] = 1'b1;
        step();
        step();
        step();
        checks++;
        if (ev_if.ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_queued: ev_valid=%b, expected 1", ev_if.ev_valid);
        end
        keys_n[3] = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ev_if.ev_ready = 1'b1;
        checks++;
        if (ev_if.ev_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmid_cleared: ev_valid=%b overflow=%b, expected 0/0",
                     ev_if.ev_valid, overflow);
        end
        nvalid = 0;
        for (int k = 0; k < 22; k++) begin
            if (k == 16) begin
                checks++;
                if (ev_if.ev_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rmid_r16: ev_valid=%b, expected 0", ev_if.ev_valid);
                end
            end
            if (k == 17) begin
                checks++;
                if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'b111) begin
                    errors++;
                    $display("FAIL rmid_r17: ev_valid=%b ev_code=%b, expected 1/111",
                             ev_if.ev_valid, ev_if.ev_code);
                end
            end
            if (ev_if.ev_valid === 1'b1) nvalid++;
            step();
        end
        keys_n[3] = 1'b1;
        repeat (6) begin
            if (ev_if.ev_valid === 1'b1) nvalid++;
            step();
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL rmid_count: %0d events, expected 1", nvalid);
        end
    endtask

    task automatic test_threshold();
        int nvalid;
        keys_n[1] = 1'b0;
        repeat (15) step();
        keys_n[1] = 1'b1;
        step();
        step();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'b001) begin
            errors++;
            $display("FAIL thr_15: ev_valid=%b ev_code=%b, expected 1/001",
                     ev_if.ev_valid, ev_if.ev_code);
        end
        repeat (4) step();
        nvalid = 0;
        keys_n[1] = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k == 16) keys_n[1] = 1'b1;
            if (k == 17) begin
                checks++;
                if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'b101) begin
                    errors++;
                    $display("FAIL thr_16: ev_valid=%b ev_code=%b, expected 1/101",
                             ev_if.ev_valid, ev_if.ev_code);
                end
            end
            if (ev_if.ev_valid === 1'b1) nvalid++;
            step();
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL thr_16_count: %0d events, expected 1", nvalid);
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_press();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        test_threshold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Downstream consumer of the per-button debounce stages in the vending-machine front end. Takes NKEYS debounced, idle-high button levels; classifies each press as short or long; arbitrates simultaneous events; queues them in a small FIFO. The FIFO presents events to the vending control FSM over a valid/ready handshake, so no press is lost while the controller is busy.

## Interface
- NKEYS, 4: number of debounced button inputs.
- DEPTH, 4: event FIFO depth, power of two.
- HOLD_LIMIT, 20'hF4240: cycles a key must stay pressed to count as a long press.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- keys_n  in  NKEYS  debounced levels, 1 = released, 0 = pressed; synchronous to clk.
- ev_valid  out  1  FIFO head holds an event.
- ev_code  out  1+clog2(NKEYS)  event at FIFO head: {long, key_idx}.
- ev_ready  in  1  consumer accepts the head this cycle.
- overflow  out  1  sticky: an event was dropped.

## Operation
- The debounce stages reset their outputs to 1, so keys_n idles high. prev_n resets to all ones; every cycle it registers keys_n.
- Per key i:
  - A press begins when prev_n[i]=1 and keys_n[i]=0.
  - A release occurs when prev_n[i]=0 and keys_n[i]=1.
- Per-key hold counter, clog2(HOLD_LIMIT) bits:
  - Cleared while keys_n[i]=1.
  - Increments while keys_n[i]=0 and long_done[i]=0.
  - Never wraps.
- Long press:
  - Trigger: counter == HOLD_LIMIT-1 and long_done[i]=0.
  - Action: set pend[i] with type LONG, set long_done[i], freeze the counter.
- Release:
  - If long_done[i]=1: no event; clear long_done[i].
  - Otherwise: set pend[i] with type SHORT.
- Arbiter:
  - Each cycle, if any pend bit is set and the FIFO is not full, pick the lowest index.
  - Write {type, idx} to the FIFO and clear that pend bit.
  - One write per cycle.
- Pend collision: if a new event for key i occurs while pend[i] is still set, drop the new event and set overflow. The held event is kept.
- FIFO:
  - ev_valid = (count != 0); ev_code = head entry.
  - Pop when ev_valid && ev_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
- Full FIFO: the arbiter stalls and pend bits persist. This is not an overflow.
- overflow clears only on reset.
- Reset values: ev_valid=0, overflow=0, count=0, pend=0, long_done=0, counters=0, prev_n=all ones.
- Key held low through reset: the first post-reset cycle is detected as a press and the hold count restarts.

## Timing
- Release seen on keys_n in cycle n: pend set at the end of n, FIFO written at the end of n+1, ev_valid=1 in n+2. This assumes an empty FIFO and no lower-index pending key.
- Long press: keys_n[i] falls in cycle p; pend is set at the end of cycle p+HOLD_LIMIT-1; ev_valid=1 in cycle p+HOLD_LIMIT+1.
- Simultaneous events on keys j<k: the FIFO holds j first, then k one cycle later.
- ev_code is stable while ev_valid=1 and ev_ready=0.
- Throughput: one event per cycle.

## Structure
- Package key_event_pkg holds:
  - EVT_SHORT=1'b0 and EVT_LONG=1'b1.
  - A function returning the event width (1+clog2(nkeys)).
- One sub-module, event_fifo, parameterised by WIDTH and DEPTH. It exposes push, din, full, pop, dout, and count.
- Edge detection, hold counters, pend bits, and the arbiter live in the top level.

## Test plan
Bench uses NKEYS=4, DEPTH=4, HOLD_LIMIT=16, and ev_ready=1 unless stated.
- Short press: key 2 low for 5 cycles, then high at cycle n -> ev_valid at n+2 with ev_code=3'b010, for exactly one cycle.
- Long press: key 1 low from cycle p and held for 40 cycles -> one ev_code=3'b101 with ev_valid at p+17; no event on release.
- Simultaneous: keys 0 and 3 released in the same cycle -> codes 3'b000 then 3'b011 on consecutive cycles.
- Backpressure: ev_ready=0 and 6 short presses on key 0, each popped... held -> 4 queued, then pend[0] held, then a sixth press sets overflow=1. After ev_ready=1, exactly 5 events drain; overflow stays 1.
- Reset mid-operation: reset during a key-3 hold (count=10) and with a non-empty FIFO -> next cycle ev_valid=0 and overflow=0. The key still held low gives a long event 16 cycles after reset deasserts, plus latency.
- Threshold boundary: key held exactly 15 cycles -> SHORT; held 16 cycles -> LONG only.
